can_bit_destuff: RTL and testbench

CAN_BIT_DESTUFF -- requirements
Module: can_bit_destuff

---
 rtl/can_pkg.sv | 15 +
 rtl/can_crc15_step.sv | 20 ++
 rtl/can_bit_destuff.sv | 159 +++++++++++++++
 tb/tb_can_bit_destuff.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared CAN constants, state encoding and defaults
package can_pkg;

    localparam logic [14:0] CRC15_POLY    = 15'h4599;
    localparam int          DEF_IDLE_BITS = 11;
    localparam int          DEF_STUFF_LEN = 5;
    localparam int          RUN_MAX       = 7;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FRAME = 2'd2
    } can_state_t;

endpackage

// File: rtl/can_crc15_step.sv
// rtl/can_crc15_step.sv - one-bit CRC-15 update, shared by RX destuffer and TX stuffer
module can_crc15_step
    import can_pkg::*;
(
    input  logic [14:0] crc_in,
    input  logic        bit_in,
    output logic [14:0] crc_out
);

    logic        nxt;
    logic [14:0] shifted;

    // Shift one bit and fold the polynomial in when the feedback bit is set
    always_comb begin
        nxt     = bit_in ^ crc_in[14];
        shifted = {crc_in[13:0], 1'b0};
        crc_out = nxt ? (shifted ^ CRC15_POLY) : shifted;
    end

endmodule

// File: rtl/can_bit_destuff.sv
// rtl/can_bit_destuff.sv - CAN RX bus-idle detection, bit destuffing and CRC-15
module can_bit_destuff
    import can_pkg::*;
#(
    parameter int IDLE_BITS = DEF_IDLE_BITS,
    parameter int STUFF_LEN = DEF_STUFF_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        rbit,
    input  logic        stuff_en,
    input  logic        crc_en,
    input  logic        frame_end,
    output logic        out_valid,
    output logic        out_bit,
    output logic        sof,
    output logic        stuff_err,
    output logic [14:0] crc,
    output logic        bus_idle
);

    localparam int IW = $clog2(IDLE_BITS + 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_BITS);
    localparam logic [2:0]    STUFF_RUN = 3'(STUFF_LEN);
    localparam logic [2:0]    RUN_SAT   = 3'(RUN_MAX);

    can_state_t  state_q, state_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic [2:0]  run_len_q, run_len_d;
    logic        last_q, last_d;
    logic [14:0] crc_q, crc_d;
    logic        out_valid_q, out_valid_d;
    logic        out_bit_q, out_bit_d;
    logic        sof_q, sof_d;
    logic        stuff_err_q, stuff_err_d;
    logic        bus_idle_q, bus_idle_d;

    logic [14:0] crc_base;
    logic [14:0] crc_next;

    // The SOF bit is folded into a cleared register; inside a frame the running value is used
    assign crc_base = (state_q == ST_IDLE) ? 15'd0 : crc_q;

    can_crc15_step u_crc_step (
        .crc_in  (crc_base),
        .bit_in  (rbit),
        .crc_out (crc_next)
    );

    // Next-state, counters and output pulses; frame_end wins over a coincident req
    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = idle_cnt_q;
        run_len_d   = run_len_q;
        last_d      = last_q;
        crc_d       = crc_q;
        out_valid_d = 1'b0;
        out_bit_d   = 1'b0;
        sof_d       = 1'b0;
        stuff_err_d = 1'b0;

        if (frame_end && (state_q == ST_FRAME)) begin
            state_d    = ST_SYNC;
            idle_cnt_d = '0;
        end else if (req) begin
            unique case (state_q)
                ST_SYNC: begin
                    if (rbit) begin
                        if (idle_cnt_q != IDLE_MAX) begin
                            idle_cnt_d = idle_cnt_q + IW'(1);
                        end
                        if ((idle_cnt_q + IW'(1)) >= IDLE_MAX) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idle_cnt_d = '0;
                    end
                end
                ST_IDLE: begin
                    if (!rbit) begin
                        sof_d       = 1'b1;
                        out_valid_d = 1'b1;
                        out_bit_d   = 1'b0;
                        crc_d       = crc_next;
                        run_len_d   = 3'd1;
                        last_d      = 1'b0;
                        state_d     = ST_FRAME;
                    end
                end
                ST_FRAME: begin
                    if (stuff_en && (run_len_q == STUFF_RUN)) begin
                        if (rbit != last_q) begin
                            run_len_d = 3'd1;
                            last_d    = rbit;
                        end else begin
                            stuff_err_d = 1'b1;
                            state_d     = ST_SYNC;
                            idle_cnt_d  = '0;
                        end
                    end else begin
                        out_valid_d = 1'b1;
                        out_bit_d   = rbit;
                        if (rbit == last_q) begin
                            run_len_d = (run_len_q == RUN_SAT) ? RUN_SAT : run_len_q + 3'd1;
                        end else begin
                            run_len_d = 3'd1;
                        end
                        last_d = rbit;
                        if (crc_en) begin
                            crc_d = crc_next;
                        end
                    end
                end
                default: begin
                    state_d    = ST_SYNC;
                    idle_cnt_d = '0;
                end
            endcase
        end

        bus_idle_d = (state_d == ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SYNC;
            idle_cnt_q  <= '0;
            run_len_q   <= 3'd0;
            last_q      <= 1'b1;
            crc_q       <= 15'd0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            sof_q       <= 1'b0;
            stuff_err_q <= 1'b0;
            bus_idle_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            run_len_q   <= run_len_d;
            last_q      <= last_d;
            crc_q       <= crc_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            sof_q       <= sof_d;
            stuff_err_q <= stuff_err_d;
            bus_idle_q  <= bus_idle_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign sof       = sof_q;
    assign stuff_err = stuff_err_q;
    assign crc       = crc_q;
    assign bus_idle  = bus_idle_q;

endmodule

// File: tb/tb_can_bit_destuff.sv
// tb/tb_can_bit_destuff.sv - self-checking bench for can_bit_destuff
module tb_can_bit_destuff;

    localparam int IDLE_BITS = 11;
    localparam int STUFF_LEN = 5;
    localparam int M_SYNC  = 0;
    localparam int M_IDLE  = 1;
    localparam int M_FRAME = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        rbit = 1'b1;
    logic        stuff_en = 1'b0;
    logic        crc_en = 1'b0;
    logic        frame_end = 1'b0;
    logic        out_valid, out_bit, sof, stuff_err, bus_idle;
    logic [14:0] crc;

    int checks = 0;
    int errors = 0;

    int m_state;
    int m_idle;
    bit hist[$];
    bit crcbits[$];
    logic exp_ov, exp_ob, exp_sof, exp_err, exp_idle;
    logic [14:0] exp_crc;
    int n_ov;
    bit tx_last;
    int tx_run;

    can_bit_destuff #(.IDLE_BITS(IDLE_BITS), .STUFF_LEN(STUFF_LEN)) dut (
        .clk(clk), .rst(rst), .req(req), .rbit(rbit), .stuff_en(stuff_en),
        .crc_en(crc_en), .frame_end(frame_end), .out_valid(out_valid),
        .out_bit(out_bit), .sof(sof), .stuff_err(stuff_err), .crc(crc),
        .bus_idle(bus_idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // CRC as the remainder of polynomial long division by x^15+x^14+x^10+x^8+x^7+x^4+x^3+1
    function automatic logic [14:0] crc_of(input bit q[$]);
        bit m[$];
        logic [15:0] g;
        logic [14:0] r;
        g = 16'hC599;
        m = q;
        for (int i = 0; i < 15; i++) m.push_back(1'b0);
        for (int i = 0; i < q.size(); i++)
            if (m[i]) for (int k = 0; k < 16; k++) m[i+k] = m[i+k] ^ g[15-k];
        for (int k = 0; k < 15; k++) r[14-k] = m[q.size()+k];
        return r;
    endfunction

    function automatic int trail_run();
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != hist[hist.size()-1] || n == 7) break;
            n++;
        end
        return n;
    endfunction

    task automatic m_reset();
        m_state = M_SYNC;
        m_idle = 0;
        hist.delete();
        crcbits.delete();
    endtask

    task automatic m_step(input bit r, input bit b, input bit se, input bit ce, input bit fe);
        int run;
        exp_ov = 0; exp_ob = 0; exp_sof = 0; exp_err = 0;
        if (fe && m_state == M_FRAME) begin
            m_state = M_SYNC;
            m_idle = 0;
        end else if (r) begin
            if (m_state == M_SYNC) begin
                if (b) begin
                    m_idle++;
                    if (m_idle >= IDLE_BITS) m_state = M_IDLE;
                end else m_idle = 0;
            end else if (m_state == M_IDLE) begin
                if (!b) begin
                    exp_sof = 1; exp_ov = 1; exp_ob = 0;
                    hist = {1'b0};
                    crcbits = {1'b0};
                    m_state = M_FRAME;
                end
            end else begin
                run = trail_run();
                if (se && run == STUFF_LEN) begin
                    if (b == hist[hist.size()-1]) begin
                        exp_err = 1;
                        m_state = M_SYNC;
                        m_idle = 0;
                    end else hist.push_back(b);
                end else begin
                    exp_ov = 1; exp_ob = b;
                    hist.push_back(b);
                    if (ce) crcbits.push_back(b);
                end
                if (hist.size() > 16) void'(hist.pop_front());
            end
        end
        exp_idle = (m_state == M_IDLE);
        exp_crc = crc_of(crcbits);
    endtask

    task automatic step(input bit r, input bit b, input bit se, input bit ce, input bit fe);
        req = r; rbit = b; stuff_en = se; crc_en = ce; frame_end = fe;
        m_step(r, b, se, ce, fe);
        @(posedge clk);
        #1;
        req = 1'b0; frame_end = 1'b0;
        if (out_valid === 1'b1) n_ov++;
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) chk("out_bit", out_bit, exp_ob);
        chk("sof", sof, exp_sof);
        chk("stuff_err", stuff_err, exp_err);
        chk("bus_idle", bus_idle, exp_idle);
        chk("crc", crc, exp_crc);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 1'b0; frame_end = 1'b0;
        #1;
        m_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bit", out_bit, 0);
        chk("rst_sof", sof, 0);
        chk("rst_stuff_err", stuff_err, 0);
        chk("rst_bus_idle", bus_idle, 0);
        chk("rst_crc", crc, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic go_idle();
        repeat (IDLE_BITS) step(1, 1, 0, 0, 0);
    endtask

    // Transmit logical bits with stuff bits inserted after five equal wire bits
    task automatic send_bits(input bit q[$], input bit ce);
        foreach (q[i]) begin
            step(1, q[i], 1, ce, 0);
            if (q[i] == tx_last) tx_run++; else begin tx_run = 1; tx_last = q[i]; end
            if (tx_run == STUFF_LEN) begin
                step(1, ~tx_last, 1, ce, 0);
                tx_last = ~tx_last;
                tx_run = 1;
            end
        end
    endtask

    initial begin
        bit q[$];
        bit crcq[$];
        logic [14:0] golden;
        logic [10:0] id;
        bit r, b, se, ce, fe;

        do_reset();

        // Ten recessive bits are not enough; an eleventh makes the bus idle
        repeat (10) step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("early_sof", sof, 0);
        chk("early_idle", bus_idle, 0);
        go_idle();
        chk("idle_reached", bus_idle, 1);
        n_ov = 0;
        step(1, 0, 1, 1, 0);
        chk("sof_pulse", sof, 1);
        chk("sof_valid", out_valid, 1);
        chk("sof_bit", out_bit, 0);

        // 0,0,0,0,0,[1],0 : the stuff bit is dropped
        repeat (4) step(1, 0, 1, 1, 0);
        step(1, 1, 1, 1, 0);
        chk("stuff_removed", out_valid, 0);
        step(1, 0, 1, 1, 0);
        chk("destuff_count", n_ov, 6);
        step(0, 0, 0, 0, 1);

        // Six dominant bits: stuff violation on the sixth
        go_idle();
        step(1, 0, 1, 1, 0);
        repeat (4) step(1, 0, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        chk("stuff_err_6th", stuff_err, 1);
        chk("stuff_err_idle", bus_idle, 0);
        step(0, 0, 1, 1, 0);
        chk("stuff_err_once", stuff_err, 0);

        // Standard frame ID 0x123, DLC 1, data 0x01
        go_idle();
        id = 11'h123;
        q = {1'b0};
        for (int i = 10; i >= 0; i--) q.push_back(id[i]);
        q.push_back(0); q.push_back(0); q.push_back(0);
        q.push_back(0); q.push_back(0); q.push_back(0); q.push_back(1);
        for (int i = 0; i < 7; i++) q.push_back(0);
        q.push_back(1);
        golden = crc_of(q);
        tx_last = 1'b1; tx_run = 0;
        send_bits(q, 1);
        chk("frame_crc", crc, golden);
        crcq.delete();
        for (int i = 14; i >= 0; i--) crcq.push_back(golden[i]);
        send_bits(crcq, 0);
        chk("crc_hold", crc, golden);
        step(0, 0, 0, 0, 1);
        chk("crc_after_end", crc, golden);

        // frame_end coincident with req discards the bit
        go_idle();
        step(1, 0, 1, 1, 0);
        step(1, 1, 1, 1, 0);
        step(1, 0, 1, 1, 1);
        chk("fe_no_valid", out_valid, 0);
        repeat (IDLE_BITS - 1) step(1, 1, 0, 0, 0);
        chk("fe_not_idle", bus_idle, 0);
        step(1, 1, 0, 0, 0);
        chk("fe_idle", bus_idle, 1);

        // Reset mid-frame aborts and requires a fresh idle run
        step(1, 0, 1, 1, 0);
        step(1, 1, 1, 1, 0);
        do_reset();
        step(1, 0, 1, 1, 0);
        chk("post_rst_no_sof", sof, 0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                r  = ($urandom_range(0, 3) != 0);
                b  = (m_state == M_FRAME) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) != 0);
                se = ($urandom_range(0, 7) != 0);
                ce = ($urandom_range(0, 3) != 0);
                fe = ($urandom_range(0, 40) == 0);
                step(r, b, se, ce, fe);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
